mac_row_drain: RTL and testbench
================================

Name: mac_row_drain

Overview:
- Output-side collector for a systolic MAC row.
- Takes the per-column partial-sum bus leaving the last row of the array. Column i's result arrives i cycles after column 0's, so the block re-aligns the columns.
- Requantizes each column to RW-bit signed with rounding, optional ReLU and saturation.
- Buffers aligned rows in a FIFO. Rows leave through a valid/ready handshake toward the output buffer / write-back path.

Parameters:
- COLUMN, 6, number of array columns (lanes per row).
- OW, 17, signed width of each incoming partial sum.
- RW, 8, signed width of each requantized output lane.
- DEPTH, 8, FIFO depth in rows; power of two, >= COLUMN+2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  column 0 of a new row is on ci this cycle; column i of the same row is valid exactly i cycles later.
- ci  in  COLUMN*OW  partial sums; lane i at [i*OW +: OW], signed.
- in_ready  out  1  producer may launch a new row this cycle.
- cfg_shift  in  4  right-shift amount for requantization, 0..15.
- cfg_relu  in  1  1 = clamp negatives to 0 before saturation.
- out_valid  out  1  FIFO head row available.
- out_ready  in  1  consumer accepts head row.
- out_data  out  COLUMN*RW  head row; lane i at [i*RW +: RW].
- empty  out  1  FIFO empty and no row in flight.
- ovf  out  1  sticky: a row was launched while in_ready=0.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1): all deskew registers and in-flight valid bits 0, FIFO pointers and count 0. Outputs: out_valid=0, out_data=0, in_ready=1, empty=1, ovf=0.
- Deskew: lane i delayed COLUMN-1-i cycles (lane COLUMN-1 undelayed). in_valid is delayed COLUMN-1 cycles through a shift chain. Aligned row and aligned valid appear together in cycle t+COLUMN-1 for in_valid at cycle t.
- Requant stage, registered, one cycle:
  - Sign-extend the lane.
  - If cfg_shift>0, add 1<<(cfg_shift-1) (round half up); the add must not overflow, so use OW+1 bits.
  - Arithmetic shift right by cfg_shift.
  - If cfg_relu, negatives become 0.
  - Saturate to [-2^(RW-1), 2^(RW-1)-1].
- Config sampling: cfg_shift and cfg_relu are sampled at the requant stage. Software changes them only when empty=1; behaviour otherwise is undefined.
- FIFO: the requant output is written at the end of cycle t+COLUMN. out_valid rises in cycle t+COLUMN+1; latency is COLUMN+1 cycles (7 at default). No fall-through.
- Output handshake:
  - out_data is registered and holds stable while out_valid=1 and out_ready=0.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Push when count==DEPTH cannot occur if in_ready is honoured.
- in_ready is combinational: (count + inflight) < DEPTH, where inflight = number of rows in the deskew and requant pipeline (0..COLUMN).
  - A pop in the same cycle is not credited, which keeps the rule conservative.
- Overflow: in_valid while in_ready=0 sets ovf. The row is dropped and its valid does not enter the chain; lane data is still shifted but ignored.
  - ovf_clr clears ovf; set wins if both occur in the same cycle.
- Rows in flight: back-to-back rows (in_valid every cycle) are supported at full throughput while in_ready=1.
- empty = (count==0) && (inflight==0).
- Reset mid-operation discards all in-flight and buffered rows immediately.

Test Plan:
- Single row: COLUMN=6, shift=0, relu=0; lane i = 10*i presented at cycle t+i, in_valid at t.
  - out_valid at t+7; out_data lanes = 0,10,20,30,40,50; empty returns to 1 after the pop.
- Rounding/saturation: shift=2, lanes = 5,6,-6,-7,1000,-1000.
  - Output 1,2,-1,-2,127,-128 (round half up: 5→1, 6→2, -6→-1, -7→-2).
- ReLU: relu=1, shift=0, lanes = -3,3,-128,127,0,200.
  - Output 0,3,0,127,0,127.
- Backpressure: out_ready=0, 10 back-to-back in_valid honouring in_ready.
  - Exactly 8 rows accepted; in_ready falls once count+inflight reaches 8.
  - Raise out_ready: rows drain in order, data intact.
- Overflow: force in_valid while in_ready=0.
  - ovf=1; that row is never output. ovf_clr → ovf=0; ovf_clr coincident with a new violation keeps ovf=1.
- Async reset asserted with 3 rows buffered and 2 in flight.
  - Immediately out_valid=0, empty=1, in_ready=1; no stale rows after release.

Source files
------------

// File: rtl/mac_row_drain.sv
// Output collector for a systolic MAC row. It re-aligns the skewed column results,
// requantizes each lane to RW bits and queues whole rows behind a valid/ready port.
module mac_row_drain #(
   parameter int unsigned COLUMN = 6,
   parameter int unsigned OW     = 17,
   parameter int unsigned RW     = 8,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid_i,
   input  logic [COLUMN*OW-1:0]   ci_i,
   output logic                   in_ready_o,
   input  logic [3:0]             cfg_shift_i,
   input  logic                   cfg_relu_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [COLUMN*RW-1:0]   out_data_o,
   output logic                   empty_o,
   output logic                   ovf_o,
   input  logic                   ovf_clr_i
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned FW = $clog2(COLUMN + 1);
   localparam int unsigned SW = $clog2(DEPTH + COLUMN + 1);
   localparam int unsigned DW = COLUMN * RW;

   localparam logic signed [OW:0] SAT_MAX = (OW+1)'((1 << (RW - 1)) - 1);
   localparam logic signed [OW:0] SAT_MIN = ~SAT_MAX;
   localparam logic [RW-1:0]      OUT_MAX = {1'b0, {(RW-1){1'b1}}};
   localparam logic [RW-1:0]      OUT_MIN = {1'b1, {(RW-1){1'b0}}};

   logic [OW-1:0]     aligned [COLUMN];
   logic [COLUMN-2:0] vld_q;
   logic              launch;
   logic              push;
   logic              pop;

   logic [DW-1:0]     rq_data_q, rq_data_d;
   logic              rq_vld_q;
   logic [DW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [FW-1:0]     inflight_q, inflight_d;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic              empty_q, empty_d;
   logic              ovf_q, ovf_d;

   // Credit check counts rows still in the deskew/requant pipe; a same-cycle pop is not credited.
   assign in_ready_o = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
   assign launch     = in_valid_i && in_ready_o;
   assign push       = rq_vld_q;
   assign pop        = out_valid_q && out_ready_i;

   // Lane i trails lane 0 by i cycles, so it is held back COLUMN-1-i cycles.
   for (genvar i = 0; i < COLUMN; i++) begin : g_lane
      localparam int unsigned D = COLUMN - 1 - i;
      if (D == 0) begin : g_direct
         assign aligned[i] = ci_i[i*OW +: OW];
      end else begin : g_dly
         logic [OW-1:0] dly_q [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < int'(D); k++) dly_q[k] <= '0;
            end else begin
               dly_q[0] <= ci_i[i*OW +: OW];
               for (int k = 1; k < int'(D); k++) dly_q[k] <= dly_q[k-1];
            end
         end
         assign aligned[i] = dly_q[D-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= launch;
         for (int k = 1; k < int'(COLUMN) - 1; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   // Requantize: round half up in OW+1 bits, arithmetic shift, optional ReLU, saturate.
   logic signed [OW:0] rnd, ext, sum, shr;
   always_comb begin
      rq_data_d = '0;
      ext       = '0;
      sum       = '0;
      shr       = '0;
      rnd       = (cfg_shift_i == 4'd0) ? '0 : ((OW+1)'(1) << (cfg_shift_i - 4'd1));
      for (int i = 0; i < int'(COLUMN); i++) begin
         ext = {aligned[i][OW-1], aligned[i]};
         sum = ext + rnd;
         shr = sum >>> cfg_shift_i;
         if (cfg_relu_i && shr[OW])  rq_data_d[i*RW +: RW] = '0;
         else if (shr > SAT_MAX)     rq_data_d[i*RW +: RW] = OUT_MAX;
         else if (shr < SAT_MIN)     rq_data_d[i*RW +: RW] = OUT_MIN;
         else                        rq_data_d[i*RW +: RW] = RW'(shr);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rq_data_q;
   end

   // Next head row comes straight from the requant register when it lands in the head slot.
   always_comb begin
      count_d     = count_q + CW'(push) - CW'(pop);
      inflight_d  = inflight_q + FW'(launch) - FW'(push);
      wr_ptr_d    = wr_ptr_q + AW'(push);
      rd_ptr_d    = rd_ptr_q + AW'(pop);
      out_valid_d = (count_d != '0);
      out_data_d  = '0;
      if (count_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) out_data_d = rq_data_q;
         else                                 out_data_d = mem_q[rd_ptr_d];
      end
      empty_d = (count_d == '0) && (inflight_d == '0);
      ovf_d   = ovf_q;
      if (ovf_clr_i)                     ovf_d = 1'b0;
      if (in_valid_i && !in_ready_o)     ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq_data_q   <= '0;
         rq_vld_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
      end else begin
         rq_data_q   <= rq_data_d;
         rq_vld_q    <= vld_q[COLUMN-2];
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         empty_q     <= empty_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign empty_o     = empty_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mac_row_drain.sv
// Directed bench for mac_row_drain: requant vector table plus backpressure,
// overflow and mid-operation reset sequences.
module tb_mac_row_drain;

   localparam int unsigned COLUMN = 6;
   localparam int unsigned OW     = 17;
   localparam int unsigned RW     = 8;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned CIW    = COLUMN * OW;
   localparam int unsigned DW     = COLUMN * RW;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic [CIW-1:0]   ci;
   logic             in_ready;
   logic [3:0]       cfg_shift;
   logic             cfg_relu;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             empty;
   logic             ovf;
   logic             ovf_clr;

   mac_row_drain #(.COLUMN(COLUMN), .OW(OW), .RW(RW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .ci_i        (ci),
      .in_ready_o  (in_ready),
      .cfg_shift_i (cfg_shift),
      .cfg_relu_i  (cfg_relu),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .empty_o     (empty),
      .ovf_o       (ovf),
      .ovf_clr_i   (ovf_clr)
   );

   typedef struct {
      logic [3:0]     shift;
      logic           relu;
      logic [CIW-1:0] row;
      logic [DW-1:0]  exp;
   } vec_t;

   vec_t           vecs [6];
   logic [CIW-1:0] hist [COLUMN];
   int             n_checks;
   int             n_errors;
   logic           s_valid, s_ready, s_empty, s_ovf;
   logic [DW-1:0]  s_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CIW-1:0] pack_in(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5);
      int a [COLUMN];
      logic [CIW-1:0] r;
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4; a[5] = a5;
      r = '0;
      for (int i = 0; i < int'(COLUMN); i++) r[i*OW +: OW] = OW'(a[i]);
      return r;
   endfunction

   function automatic logic [DW-1:0] pack_out(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5);
      int a [COLUMN];
      logic [DW-1:0] r;
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4; a[5] = a5;
      r = '0;
      for (int i = 0; i < int'(COLUMN); i++) r[i*RW +: RW] = RW'(a[i]);
      return r;
   endfunction

   function automatic logic [CIW-1:0] bp_row(input int k);
      return pack_in(10*k, 10*k+1, 10*k+2, 10*k+3, 10*k+4, 10*k+5);
   endfunction

   function automatic logic [DW-1:0] bp_exp(input int k);
      return pack_out(10*k, 10*k+1, 10*k+2, 10*k+3, 10*k+4, 10*k+5);
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle: present lane i of the row launched i cycles ago, sample mid-cycle.
   task automatic cyc(input logic v, input logic [CIW-1:0] row);
      for (int k = int'(COLUMN) - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = row;
      for (int i = 0; i < int'(COLUMN); i++) ci[i*OW +: OW] = hist[i][i*OW +: OW];
      in_valid = v;
      @(negedge clk);
      s_valid = out_valid;
      s_ready = in_ready;
      s_empty = empty;
      s_ovf   = ovf;
      s_data  = out_data;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int attempts, output int accepted);
      logic v;
      accepted = 0;
      for (int n = 0; n < attempts; n++) begin
         v = in_ready;
         cyc(v, bp_row(accepted));
         if (v) accepted++;
      end
   endtask

   task automatic drain(input int nexp);
      int got;
      got = 0;
      out_ready = 1'b1;
      for (int n = 0; n < 40 && got < nexp + 1; n++) begin
         cyc(1'b0, '0);
         if (s_valid) begin
            chk($sformatf("drain_row%0d", got), s_data, bp_exp(got));
            got++;
         end
      end
      chk("drain_count", got, nexp);
      chk("drain_empty", s_empty, 1);
   endtask

   int accepted;
   int stale;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      ci        = '0;
      cfg_shift = 4'd0;
      cfg_relu  = 1'b0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      for (int k = 0; k < int'(COLUMN); k++) hist[k] = '0;

      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_ovf", ovf, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      vecs[0] = '{4'd0,  1'b0, pack_in(0, 10, 20, 30, 40, 50),             pack_out(0, 10, 20, 30, 40, 50)};
      vecs[1] = '{4'd2,  1'b0, pack_in(5, 6, -6, -7, 1000, -1000),         pack_out(1, 2, -1, -2, 127, -128)};
      vecs[2] = '{4'd0,  1'b1, pack_in(-3, 3, -128, 127, 0, 200),          pack_out(0, 3, 0, 127, 0, 127)};
      vecs[3] = '{4'd1,  1'b0, pack_in(1, -1, 3, -3, 255, -257),           pack_out(1, 0, 2, -1, 127, -128)};
      vecs[4] = '{4'd15, 1'b0, pack_in(65535, -65536, 16384, 16383, -16384, -16385),
                                                                          pack_out(2, -2, 1, 0, 0, -1)};
      vecs[5] = '{4'd4,  1'b1, pack_in(-100, 100, 2047, 2048, -8, 8),      pack_out(0, 6, 127, 127, 0, 1)};

      out_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         cfg_shift = vecs[v].shift;
         cfg_relu  = vecs[v].relu;
         cyc(1'b1, vecs[v].row);
         repeat (6) cyc(1'b0, '0);
         chk($sformatf("vec%0d_early", v), s_valid, 0);
         cyc(1'b0, '0);
         chk($sformatf("vec%0d_valid", v), s_valid, 1);
         chk($sformatf("vec%0d_data", v), s_data, vecs[v].exp);
         cyc(1'b0, '0);
         chk($sformatf("vec%0d_empty", v), s_empty, 1);
      end
      cfg_shift = 4'd0;
      cfg_relu  = 1'b0;

      // Backpressure: the credit rule admits exactly DEPTH rows.
      out_ready = 1'b0;
      fill(10, accepted);
      chk("bp_accepted", accepted, DEPTH);
      chk("bp_ready_low", s_ready, 0);
      repeat (8) cyc(1'b0, '0);
      chk("bp_valid", s_valid, 1);
      chk("bp_ready_full", s_ready, 0);
      drain(DEPTH);

      // Overflow: dropped rows never appear; set wins over a coincident clear.
      out_ready = 1'b0;
      fill(10, accepted);
      cyc(1'b1, pack_in(99, 99, 99, 99, 99, 99));
      cyc(1'b0, '0);
      chk("ovf_set", s_ovf, 1);
      ovf_clr = 1'b1;
      cyc(1'b0, '0);
      ovf_clr = 1'b0;
      cyc(1'b0, '0);
      chk("ovf_cleared", s_ovf, 0);
      ovf_clr = 1'b1;
      cyc(1'b1, pack_in(99, 99, 99, 99, 99, 99));
      ovf_clr = 1'b0;
      cyc(1'b0, '0);
      chk("ovf_set_wins", s_ovf, 1);
      drain(DEPTH);
      ovf_clr = 1'b1;
      cyc(1'b0, '0);
      ovf_clr = 1'b0;

      // Async reset with three rows buffered and two in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) cyc(1'b1, bp_row(k));
      repeat (4) cyc(1'b0, '0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_empty", empty, 0);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_empty", empty, 1);
      chk("async_rst_ready", in_ready, 1);
      chk("async_rst_data", out_data, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      repeat (15) begin
         cyc(1'b0, '0);
         if (s_valid) stale++;
      end
      chk("post_rst_stale", stale, 0);
      chk("post_rst_empty", s_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
